bounce_gen: RTL
===============

Name: bounce_gen

Overview:
- Parametrised successor to the team's single-speed bouncing-position generator for the video/game path.
- Produces a 2-D object position that advances by a programmable per-axis speed on each enable tick and reflects at configurable margins.
- Adds serve/pause/stop control FSM, clamped reflection for speeds >1, registered hit pulses and a saturating bounce counter.
- Sits between the frame-tick generator (drives tick) and the sprite renderer/score logic.

Parameters:
W, 11, width of position outputs
XMAX, 1024, horizontal extent (pixels)
YMAX, 768, vertical extent (lines)
MARGIN, 32, reflection margin on every edge
SW, 4, width of speed inputs
CW, 16, width of bounce counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
tick  in  1  advance enable, one step per cycle high
serve  in  1  pulse: start motion from IDLE, latch speeds
pause  in  1  level: hold motion while high (RUN only)
stop  in  1  pulse: return to IDLE, recentre
spd_x  in  SW  horizontal step size, sampled on serve
spd_y  in  SW  vertical step size, sampled on serve
pos_x  out  W  current x position
pos_y  out  W  current y position
dir_x  out  1  1 = increasing x, 0 = decreasing
dir_y  out  1  1 = increasing y, 0 = decreasing
hit_x  out  1  one-cycle pulse: x reflected
hit_y  out  1  one-cycle pulse: y reflected
bounces  out  CW  saturating reflection count
running  out  1  high in RUN state

Behaviour:
- One clock; reset is synchronous and active-high.
- All state updates on the rising edge of clk.
- Reset values:
  - pos_x = XMAX/2, pos_y = YMAX/2
  - dir_x = dir_y = 0
  - hit_x = hit_y = 0, bounces = 0, running = 0
  - latched speeds = 1, state IDLE
- Limits:
  - LOX = LOY = MARGIN
  - HIX = XMAX-MARGIN, HIY = YMAX-MARGIN
  - Compare arithmetic is done in W+1 bits; no wrap.
- FSM states: IDLE, RUN, PAUSED. Priority per cycle: rst > stop > serve > pause.
  - IDLE: position held at centre. serve=1 -> RUN next cycle; latch spd_x/spd_y, with value 0 replaced by 1. tick ignored.
  - RUN: pause=1 -> PAUSED, and no step that cycle even if tick=1. stop=1 -> IDLE.
  - PAUSED: pause=0 -> RUN; the step resumes on the next tick. stop=1 -> IDLE. serve ignored.
  - stop (any state): next cycle pos = centre, dir = 0, hits = 0, state IDLE. bounces retained; only rst clears it.
  - serve outside IDLE: ignored, speeds not relatched.
- Step: in RUN with tick=1 and pause=0, each axis updates independently in the same cycle.
  - dir=1: if pos+spd >= HI, then pos <= HI, dir <= 0, hit <= 1. Else pos <= pos+spd.
  - dir=0: if pos <= LO+spd, then pos <= LO, dir <= 1, hit <= 1. Else pos <= pos-spd.
  - Reflection lands exactly on the limit (clamp); there is no overshoot.
- Outputs:
  - pos/dir are registers, so the new value is visible the cycle after the tick.
  - hit_x/hit_y are registered and high exactly one cycle, coincident with the updated pos. They are 0 in every other cycle.
  - bounces increments by hit_x_next + hit_y_next (0, 1 or 2) in the same cycle. It saturates at 2^CW-1 with no wrap; a +2 from 2^CW-2 gives 2^CW-1.
- Corner hit (both axes reflect in one tick): both pulses high together, counter +2.
- Static constraints:
  - 2*MARGIN < YMAX <= XMAX < 2^W
  - 2^SW-1 < YMAX-2*MARGIN
  - A simulation assertion flags any violation.

Test Plan:
- Reset/idle: assert rst 3 cycles, then 20 ticks with no serve -> pos=(512,384), dir=0, running=0, bounces=0 throughout.
- Clamped reflection: serve with spd_x=4, spd_y=0; 120 ticks.
  - x at tick 119 = 36; tick 120 -> x=32, hit_x=1 for one cycle, dir_x=1.
  - Tick 121 -> x=36.
  - y (speed clamped to 1) after 120 ticks = 264.
- High edge with non-multiple speed: serve spd_x=7 from x=512. After the low reflection at 32, run up until x+7 >= 992 -> x=992 exactly, hit_x, dir_x=0. Check that no position exceeds 992.
- Corner: XMAX=YMAX=128, MARGIN=8, spd 4/4; serve -> both axes reach 8 on tick 14. hit_x=hit_y=1 same cycle, bounces 0 -> 2.
- Pause/stop: pause high for 10 ticks mid-run -> pos frozen, running=0. Release -> motion resumes on the next tick. stop pulse -> next cycle pos=(512,384), dir=0, IDLE, bounces unchanged. serve during PAUSED ignored.
- Saturation/reset priority: CW=4, run until bounces=15, then further hits -> stays 15. Assert rst concurrently with serve and tick -> reset values win.

Source files
------------

// File: rtl/bounce_gen_if.sv
// Control/status bundle between the frame-tick side and bounce_gen.
interface bounce_gen_if #(
   parameter int W  = 11,
   parameter int SW = 4,
   parameter int CW = 16
);
   logic          tick;
   logic          serve;
   logic          pause;
   logic          stop;
   logic [SW-1:0] spd_x;
   logic [SW-1:0] spd_y;
   logic [W-1:0]  pos_x;
   logic [W-1:0]  pos_y;
   logic          dir_x;
   logic          dir_y;
   logic          hit_x;
   logic          hit_y;
   logic [CW-1:0] bounces;
   logic          running;

   modport master (
      output tick, serve, pause, stop, spd_x, spd_y,
      input  pos_x, pos_y, dir_x, dir_y, hit_x, hit_y, bounces, running
   );

   modport slave (
      input  tick, serve, pause, stop, spd_x, spd_y,
      output pos_x, pos_y, dir_x, dir_y, hit_x, hit_y, bounces, running
   );
endinterface

// File: rtl/bounce_gen.sv
// 2-D bouncing position generator: per-axis programmable speed, clamped
// reflection at the margins, serve/pause/stop control, hit pulses and a
// saturating bounce counter.
module bounce_gen #(
   parameter int W      = 11,
   parameter int XMAX   = 1024,
   parameter int YMAX   = 768,
   parameter int MARGIN = 32,
   parameter int SW     = 4,
   parameter int CW     = 16
) (
   input  logic         clk,
   input  logic         rst,
   bounce_gen_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

   localparam logic [W-1:0]  LOX  = W'(MARGIN);
   localparam logic [W-1:0]  HIX  = W'(XMAX - MARGIN);
   localparam logic [W-1:0]  LOY  = W'(MARGIN);
   localparam logic [W-1:0]  HIY  = W'(YMAX - MARGIN);
   localparam logic [W-1:0]  CX   = W'(XMAX / 2);
   localparam logic [W-1:0]  CY   = W'(YMAX / 2);
   localparam logic [CW-1:0] BMAX = '1;
   localparam bit CFG_OK = (2 * MARGIN < YMAX) && (YMAX <= XMAX) &&
                           (XMAX < 2 ** W) && ((2 ** SW) - 1 < YMAX - 2 * MARGIN);

   state_t        state_q, state_d;
   logic [W-1:0]  pos_x_q, pos_x_d, pos_y_q, pos_y_d;
   logic          dir_x_q, dir_x_d, dir_y_q, dir_y_d;
   logic          hit_x_q, hit_x_d, hit_y_q, hit_y_d;
   logic [CW-1:0] bounces_q, bounces_d;
   logic          running_q, running_d;
   logic [SW-1:0] spd_x_q, spd_x_d, spd_y_q, spd_y_d;
   logic [W+1:0]  nx, ny;
   logic [CW:0]   bsum;

   // One axis step in W+1 bits; returns {hit, new_dir, new_pos}.
   // Reflection clamps to the limit so speeds >1 never overshoot.
   function automatic logic [W+1:0] axis_next(input logic [W-1:0]  pos,
                                              input logic          dir,
                                              input logic [SW-1:0] spd,
                                              input logic [W-1:0]  lo,
                                              input logic [W-1:0]  hi);
      logic [W:0] up, dn, dn_lim;
      up     = {1'b0, pos} + (W+1)'(spd);
      dn     = {1'b0, pos} - (W+1)'(spd);
      dn_lim = {1'b0, lo} + (W+1)'(spd);
      if (dir)
         return (up >= {1'b0, hi}) ? {1'b1, 1'b0, hi} : {1'b0, 1'b1, W'(up)};
      else
         return ({1'b0, pos} <= dn_lim) ? {1'b1, 1'b1, lo} : {1'b0, 1'b0, W'(dn)};
   endfunction

   assign nx = axis_next(pos_x_q, dir_x_q, spd_x_q, LOX, HIX);
   assign ny = axis_next(pos_y_q, dir_y_q, spd_y_q, LOY, HIY);

   // Next-state: stop overrides everything, then per-state serve/pause/step.
   always_comb begin
      state_d = state_q;
      pos_x_d = pos_x_q;
      pos_y_d = pos_y_q;
      dir_x_d = dir_x_q;
      dir_y_d = dir_y_q;
      spd_x_d = spd_x_q;
      spd_y_d = spd_y_q;
      hit_x_d = 1'b0;
      hit_y_d = 1'b0;
      if (bus.stop) begin
         state_d = IDLE;
         pos_x_d = CX;
         pos_y_d = CY;
         dir_x_d = 1'b0;
         dir_y_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: if (bus.serve) begin
               state_d = RUN;
               spd_x_d = (bus.spd_x == '0) ? SW'(1) : bus.spd_x;
               spd_y_d = (bus.spd_y == '0) ? SW'(1) : bus.spd_y;
            end
            RUN: if (bus.pause) begin
               state_d = PAUSED;
            end else if (bus.tick) begin
               {hit_x_d, dir_x_d, pos_x_d} = nx;
               {hit_y_d, dir_y_d, pos_y_d} = ny;
            end
            PAUSED: if (!bus.pause) state_d = RUN;
            default: state_d = IDLE;
         endcase
      end
      // Saturating add of 0..2 reflections; the carry bit flags overflow.
      bsum      = {1'b0, bounces_q} + (CW+1)'(hit_x_d) + (CW+1)'(hit_y_d);
      bounces_d = bsum[CW] ? BMAX : bsum[CW-1:0];
      running_d = (state_d == RUN);
   end

   // State and registered outputs with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pos_x_q   <= CX;
         pos_y_q   <= CY;
         dir_x_q   <= 1'b0;
         dir_y_q   <= 1'b0;
         hit_x_q   <= 1'b0;
         hit_y_q   <= 1'b0;
         bounces_q <= '0;
         running_q <= 1'b0;
         spd_x_q   <= SW'(1);
         spd_y_q   <= SW'(1);
      end else begin
         state_q   <= state_d;
         pos_x_q   <= pos_x_d;
         pos_y_q   <= pos_y_d;
         dir_x_q   <= dir_x_d;
         dir_y_q   <= dir_y_d;
         hit_x_q   <= hit_x_d;
         hit_y_q   <= hit_y_d;
         bounces_q <= bounces_d;
         running_q <= running_d;
         spd_x_q   <= spd_x_d;
         spd_y_q   <= spd_y_d;
      end
   end

   // Flag an illegal geometry/speed parameter set in simulation.
   always_ff @(posedge clk) begin
      assert (CFG_OK) else $error("bounce_gen: illegal parameter combination");
   end

   assign bus.pos_x   = pos_x_q;
   assign bus.pos_y   = pos_y_q;
   assign bus.dir_x   = dir_x_q;
   assign bus.dir_y   = dir_y_q;
   assign bus.hit_x   = hit_x_q;
   assign bus.hit_y   = hit_y_q;
   assign bus.bounces = bounces_q;
   assign bus.running = running_q;

endmodule
